// File: rtl/d_cache_wb_pkg.sv
// Shared types and constants for the data-cache write-back buffer.
// ADDR_WIDTH / DATA_WIDTH fall back to 32 bits when the build does not set them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package d_cache_wb_pkg;

  localparam int WB_ADDR_W     = `ADDR_WIDTH;
  localparam int WB_DATA_W     = `DATA_WIDTH;
  localparam int WB_BYTE_OFF_W = 2;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_RESP} fill_state_t;
  typedef enum logic [1:0] {D_IDLE, D_ADDR, D_DATA, D_RESP} drain_state_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [3:0]           len;
  } wb_entry_t;

  // Byte-address bits below the line address.
  function automatic int line_off_w(input int line_words);
    return $clog2(line_words) + WB_BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/d_cache_write_buffer_line_store.sv
// Line data storage: one synchronous write port, one asynchronous read port.
module wb_line_store #(
  parameter  int NUM_ENTRIES = 2,
  parameter  int LINE_WORDS  = 4,
  parameter  int DATA_W      = 32,
  localparam int PTR_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int WRD_W       = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  wr_entry_i,
  input  logic [WRD_W-1:0]  wr_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [PTR_W-1:0]  rd_entry_i,
  input  logic [WRD_W-1:0]  rd_word_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [NUM_ENTRIES][LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_entry_i][wr_word_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_entry_i][rd_word_i];

endmodule

// File: rtl/d_cache_write_buffer.sv
// Write-back buffer between the data cache AXI master and memory: early flush ack, FIFO drain.
// Define D_CACHE_WB_RAW_CHECK_EN to let reads to non-buffered lines bypass pending writes.
module d_cache_write_buffer
  import d_cache_wb_pkg::*;
#(
  parameter int LINE_WORDS  = 4,
  parameter int NUM_ENTRIES = 2,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int DATA_W      = WB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [3:0]        s_awlen,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic              s_wlast,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [3:0]        m_awlen,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wlast,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              wb_empty
);

  localparam int OFF_W = line_off_w(LINE_WORDS);
  localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_ENTRIES - 1);
  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_ENTRIES);

  fill_state_t      fstate_q;
  drain_state_t     dstate_q;
  wb_entry_t        entry_q [NUM_ENTRIES];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [WRD_W-1:0] beat_q, dbeat_q;
  logic [CNT_W-1:0] count_q;
  logic             run_q;
  logic             aw_hs, w_hs, commit, pop, hazard;
  logic             wlast_unused;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign wlast_unused = s_wlast;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign commit = w_hs & (beat_q == LAST_WORD);
  assign pop    = (dstate_q == D_RESP) & m_bvalid;

  // run_q keeps every ready low while reset is asserted, including the read bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate_q <= F_IDLE;
      beat_q   <= '0;
      wr_ptr_q <= '0;
    end else begin
      case (fstate_q)
        F_IDLE: if (aw_hs) begin
          fstate_q <= F_DATA;
          beat_q   <= '0;
        end
        F_DATA: if (w_hs) begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == LAST_WORD) begin
            fstate_q <= F_RESP;
            wr_ptr_q <= ptr_inc(wr_ptr_q);
          end
        end
        F_RESP:  if (s_bready) fstate_q <= F_IDLE;
        default: fstate_q <= F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate_q <= D_IDLE;
      dbeat_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      case (dstate_q)
        D_IDLE: if (entry_q[rd_ptr_q].valid) dstate_q <= D_ADDR;
        D_ADDR: if (m_awready) begin
          dstate_q <= D_DATA;
          dbeat_q  <= '0;
        end
        D_DATA: if (m_wready) begin
          dbeat_q <= dbeat_q + 1'b1;
          if (dbeat_q == LAST_WORD) dstate_q <= D_RESP;
        end
        D_RESP: if (m_bvalid) begin
          dstate_q <= D_IDLE;
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
        default: dstate_q <= D_IDLE;
      endcase
    end
  end

  // Entry bookkeeping is shared by both machines, so it lives in one process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
      count_q <= '0;
    end else begin
      if (aw_hs) begin
        entry_q[wr_ptr_q].addr <= s_awaddr;
        entry_q[wr_ptr_q].len  <= s_awlen;
      end
      if (commit) entry_q[wr_ptr_q].valid <= 1'b1;
      if (pop)    entry_q[rd_ptr_q].valid <= 1'b0;
      case ({commit, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  wb_line_store #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .LINE_WORDS (LINE_WORDS),
    .DATA_W     (DATA_W)
  ) u_store (
    .clk       (clk),
    .we_i      (w_hs),
    .wr_entry_i(wr_ptr_q),
    .wr_word_i (beat_q),
    .wr_data_i (s_wdata),
    .rd_entry_i(rd_ptr_q),
    .rd_word_i (dbeat_q),
    .rd_data_o (m_wdata)
  );

  assign s_awready = run_q & (fstate_q == F_IDLE) & (count_q < FULL_CNT);
  assign s_wready  = (fstate_q == F_DATA);
  assign s_bvalid  = (fstate_q == F_RESP);
  assign m_awvalid = (dstate_q == D_ADDR);
  assign m_awaddr  = entry_q[rd_ptr_q].addr;
  assign m_awlen   = entry_q[rd_ptr_q].len;
  assign m_wvalid  = (dstate_q == D_DATA);
  assign m_wlast   = (dstate_q == D_DATA) & (dbeat_q == LAST_WORD);
  assign m_bready  = (dstate_q == D_RESP);
  assign wb_empty  = (count_q == '0) & (fstate_q == F_IDLE);

`ifdef D_CACHE_WB_RAW_CHECK_EN
  logic line_hit;
  // Only the filling entry is checked in F_DATA; once committed it is covered by its valid bit.
  always_comb begin
    line_hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entry_q[i].valid && (entry_q[i].addr[ADDR_W-1:OFF_W] == s_araddr[ADDR_W-1:OFF_W]))
        line_hit = 1'b1;
    end
    if ((fstate_q == F_DATA) &&
        (entry_q[wr_ptr_q].addr[ADDR_W-1:OFF_W] == s_araddr[ADDR_W-1:OFF_W]))
      line_hit = 1'b1;
  end
  assign hazard = s_arvalid & line_hit;
`else
  assign hazard = ~wb_empty;
`endif

  assign m_araddr  = s_araddr;
  assign m_arvalid = run_q & s_arvalid & ~hazard;
  assign s_arready = run_q & m_arready & ~hazard;

endmodule

// File: tb/tb_d_cache_write_buffer.sv
// Scoreboard bench for d_cache_write_buffer: random flushes, random memory stalls, read ordering.
module tb_d_cache_write_buffer;
  import d_cache_wb_pkg::*;

  localparam int NE  = 2;
  localparam int LW  = 4;
  localparam int AW  = WB_ADDR_W;
  localparam int DW  = WB_DATA_W;
  localparam int OFF = $clog2(LW) + 2;

  logic clk, rst_n;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic s_arvalid, s_arready;
  logic [AW-1:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [3:0] s_awlen, m_awlen;
  logic [DW-1:0] s_wdata, m_wdata;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic m_arvalid, m_arready, wb_empty;

  d_cache_write_buffer #(.LINE_WORDS(LW), .NUM_ENTRIES(NE), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .wb_empty(wb_empty)
  );

  typedef struct {
    logic [AW-1:0]    addr;
    logic [LW*DW-1:0] data;
  } line_t;

  int vectors = 0, miscompares = 0;
  line_t exp_q[$];
  logic [AW-1:0] held_q[$];
  int fphase = 0, fbeats = 0, mbeat = 0, bpend = 0;
  bit settled = 0, reads_en = 0, aw_stall = 0, rd_fixed = 0;
  logic [AW-1:0] rd_fixed_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Reference model: fphase 0/1/2 = awaiting AW / taking beats / acking; held_q = lines accepted, not yet written to memory.
  always @(negedge clk) begin : monitor
    bit emp, hit, haz;
    if (!rst_n) begin
      exp_q.delete();
      held_q.delete();
      fphase = 0; fbeats = 0; mbeat = 0;
    end else if (settled) begin
      emp = (held_q.size() == 0) && (fphase == 0);
      chk("wb_empty", wb_empty, emp);
      chk("s_awready", s_awready, (fphase == 0) && (held_q.size() < NE));
      chk("s_wready", s_wready, fphase == 1);
      chk("s_bvalid", s_bvalid, fphase == 2);
      hit = 0;
      foreach (held_q[i]) if (held_q[i][AW-1:OFF] == s_araddr[AW-1:OFF]) hit = 1;
`ifdef D_CACHE_WB_RAW_CHECK_EN
      haz = s_arvalid && hit;
`else
      haz = !emp;
`endif
      chk("m_arvalid", m_arvalid, s_arvalid && !haz);
      chk("s_arready", s_arready, m_arready && !haz);
      chk("m_araddr", m_araddr, s_araddr);
      if (m_awvalid && m_awready) begin
        if (exp_q.size() == 0) timeout("m_aw_unexpected");
        else begin
          chk("m_awaddr", m_awaddr, exp_q[0].addr);
          chk("m_awlen", m_awlen, 4'd3);
        end
      end
      if (m_wvalid && m_wready) begin
        if (exp_q.size() == 0) timeout("m_w_unexpected");
        else begin
          chk("m_wdata", m_wdata, exp_q[0].data[mbeat*DW +: DW]);
          chk("m_wlast", m_wlast, mbeat == LW - 1);
          mbeat++;
          if (mbeat == LW) begin
            mbeat = 0;
            void'(exp_q.pop_front());
          end
        end
      end
      if (s_awvalid && s_awready) begin
        held_q.push_back(s_awaddr);
        fphase = 1; fbeats = 0;
      end
      if (s_wvalid && s_wready) begin
        fbeats++;
        if (fbeats == LW) fphase = 2;
      end
      if (s_bvalid && s_bready) fphase = 0;
      if (m_bvalid && m_bready && held_q.size() > 0) void'(held_q.pop_front());
    end
  end

  initial begin : mem_slave
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) bpend = 0;
      else begin
        if (m_wvalid && m_wready && m_wlast) bpend++;
        if (m_bvalid && m_bready) bpend--;
      end
      @(posedge clk); #1;
      m_awready = !aw_stall && ($urandom_range(0, 3) != 0);
      m_wready  = $urandom_range(0, 3) != 0;
      m_bvalid  = rst_n && (bpend > 0) && (m_bvalid || ($urandom_range(0, 1) == 1));
      m_arready = $urandom_range(0, 3) != 0;
    end
  end

  initial begin : rd_driver
    s_arvalid = 0; s_araddr = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_fixed) begin
        s_arvalid = 1; s_araddr = rd_fixed_addr;
      end else begin
        s_arvalid = reads_en && ($urandom_range(0, 1) == 1);
        s_araddr  = AW'($urandom_range(1, 7) * 256 + $urandom_range(0, 15));
      end
    end
  end

  task automatic flush(input logic [AW-1:0] a, input bit fast_b);
    line_t ln;
    bit hs;
    int guard;
    ln.addr = a;
    for (int i = 0; i < LW; i++) ln.data[i*DW +: DW] = DW'($urandom);
    exp_q.push_back(ln);
    @(posedge clk); #1;
    s_awvalid = 1; s_awaddr = a; s_awlen = 4'd3;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!s_awready && guard < 3000);
    if (!s_awready) begin timeout("s_aw_wait"); s_awvalid = 0; return; end
    @(posedge clk); #1;
    s_awvalid = 0;
    guard = 0;
    for (int b = 0; b < LW && guard < 500; guard++) begin
      s_wvalid = $urandom_range(0, 3) != 0;
      s_wdata  = ln.data[b*DW +: DW];
      s_wlast  = (b == LW - 1);
      @(negedge clk);
      hs = s_wvalid && s_wready;
      @(posedge clk); #1;
      if (hs) b++;
    end
    s_wvalid = 0; s_wlast = 0;
    if (guard >= 500) begin timeout("s_w_wait"); return; end
    guard = 0;
    hs = 0;
    while (!hs && guard < 500) begin
      s_bready = fast_b || ($urandom_range(0, 2) == 0);
      @(negedge clk);
      hs = s_bvalid && s_bready;
      @(posedge clk); #1;
      guard++;
    end
    s_bready = 0;
    if (!hs) timeout("s_b_wait");
  endtask

  task automatic wait_empty();
    int guard = 0;
    do begin @(negedge clk); guard++; end while (!wb_empty && guard < 3000);
    if (!wb_empty) timeout("wb_empty_wait");
  endtask

  function automatic logic [8:0] ctl_outs();
    return {s_awready, s_wready, s_bvalid, s_arready, m_awvalid, m_wvalid, m_bready, m_arvalid, wb_empty};
  endfunction

  initial begin : main
    int guard;
    rst_n = 0;
    s_awvalid = 0; s_awaddr = '0; s_awlen = '0;
    s_wvalid = 0; s_wdata = '0; s_wlast = 0; s_bready = 0;
    repeat (3) @(posedge clk);
    #2 chk("reset_outs", ctl_outs(), 9'b000000001);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 settled = 1;

    flush(AW'('h100), 1);
    wait_empty();

    aw_stall = 1;
    flush(AW'('h100), 1);
    flush(AW'('h200), 1);
    @(negedge clk);
    chk("full_awready", s_awready, 1'b0);
    fork
      flush(AW'('h300), 0);
      begin repeat (30) @(posedge clk); #1 aw_stall = 0; end
    join
    wait_empty();

    aw_stall = 1;
    flush(AW'('h200), 1);
    rd_fixed_addr = AW'('h400); rd_fixed = 1;
    repeat (8) @(posedge clk);
    #1 rd_fixed_addr = AW'('h208);
    repeat (8) @(posedge clk);
    #1 aw_stall = 0;
    wait_empty();
    repeat (3) @(posedge clk);
    #1 rd_fixed = 0;

    reads_en = 1;
    for (int n = 0; n < 40; n++) begin
      flush(AW'($urandom_range(1, 7) * 256), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_empty();
    reads_en = 0;

    flush(AW'('h300), 1);
    guard = 0;
    do begin @(negedge clk); #1; guard++; end while (mbeat != 2 && guard < 1000);
    if (mbeat != 2) timeout("drain_beat2_wait");
    @(posedge clk); #3;
    settled = 0;
    rst_n = 0;
    #1 chk("async_reset_outs", ctl_outs(), 9'b000000001);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1 settled = 1;
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_m_wvalid", m_wvalid, 1'b0);
    end
    chk("post_reset_empty", wb_empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
